// File: rtl/cache_pkg.sv
// Shared types and address helpers for the direct-mapped write-through cache.
// Geometry defaults here must match the parameters of write_through_cache.
package cache_pkg;

    localparam int unsigned CFG_ADDR_WIDTH  = 10;
    localparam int unsigned CFG_DATA_WIDTH  = 32;
    localparam int unsigned CFG_BLOCK_WORDS = 4;
    localparam int unsigned CFG_NUM_LINES   = 32;
    localparam int unsigned CFG_MEM_LAT     = 4;

    localparam int unsigned OFF_W = $clog2(CFG_BLOCK_WORDS);
    localparam int unsigned IDX_W = $clog2(CFG_NUM_LINES);
    localparam int unsigned TAG_W = CFG_ADDR_WIDTH - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_MEM  = 2'd2
    } state_t;

    typedef logic [CFG_ADDR_WIDTH-1:0] addr_t;
    typedef logic [TAG_W-1:0]          tag_t;
    typedef logic [IDX_W-1:0]          idx_t;
    typedef logic [OFF_W-1:0]          off_t;

    function automatic tag_t addr_tag(input addr_t a);
        return a[CFG_ADDR_WIDTH-1 -: TAG_W];
    endfunction

    function automatic idx_t addr_idx(input addr_t a);
        return a[OFF_W +: IDX_W];
    endfunction

    function automatic off_t addr_off(input addr_t a);
        return a[OFF_W-1:0];
    endfunction

    // Aligned first word of the block holding the given line.
    function automatic addr_t block_base(input tag_t t, input idx_t i);
        return {t, i, OFF_W'(0)};
    endfunction

endpackage

// File: rtl/main_memory_model.sv
// Fixed-content main memory: combinational aligned block read, clocked word write.
// Start-up contents are mem[i] = i; the array is never cleared by reset.
module main_memory_model #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BLOCK_WORDS = 4
) (
    input  logic                                  clk,
    input  logic [ADDR_WIDTH-1:0]                 block_addr,
    output logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] block_data,
    input  logic                                  wr_en,
    input  logic [ADDR_WIDTH-1:0]                 wr_addr,
    input  logic [DATA_WIDTH-1:0]                 wr_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned IMG_W = DEPTH * DATA_WIDTH;
    localparam int unsigned BLK_W = BLOCK_WORDS * DATA_WIDTH;

    function automatic logic [IMG_W-1:0] startup_image();
        logic [IMG_W-1:0] img;
        img = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            img[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(i);
        end
        return img;
    endfunction

    // Flat image keeps the word-per-address contents without an init process.
    logic [IMG_W-1:0] mem = startup_image();

    always_comb begin
        block_data = mem[32'(block_addr) * DATA_WIDTH +: BLK_W];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[32'(wr_addr) * DATA_WIDTH +: DATA_WIDTH] <= wr_data;
        end
    end

endmodule

// File: rtl/write_through_cache.sv
// Direct-mapped write-through, no-write-allocate cache with its backing memory model.
// Optional hit/miss statistics ports are built when CACHE_STATS_EN is defined.
module write_through_cache
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = CFG_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = CFG_DATA_WIDTH,
    parameter int unsigned BLOCK_WORDS = CFG_BLOCK_WORDS,
    parameter int unsigned NUM_LINES   = CFG_NUM_LINES,
    parameter int unsigned MEM_LAT     = CFG_MEM_LAT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] WordAddress,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] DataOut
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
`endif
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

    typedef logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] line_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  req_hit;

    logic [NUM_LINES-1:0]  valid;
    tag_t                  tag_array [NUM_LINES];
    line_t                 data_array [NUM_LINES];

    tag_t  cur_tag;
    idx_t  cur_idx;
    off_t  cur_off;
    tag_t  req_tag;
    idx_t  req_idx;
    off_t  req_off;
    logic  hit;
    logic  cnt_done;

    logic  acc_rd_hit;
    logic  acc_rd_miss;
    logic  acc_wr;
    logic  fill_done;
    logic  wr_done;

    line_t                 mem_block;
    logic [ADDR_WIDTH-1:0] mem_block_addr;

    // Address decode for the live request and the latched one.
    always_comb begin
        cur_tag  = addr_tag(WordAddress);
        cur_idx  = addr_idx(WordAddress);
        cur_off  = addr_off(WordAddress);
        req_tag  = addr_tag(req_addr);
        req_idx  = addr_idx(req_addr);
        req_off  = addr_off(req_addr);
        hit      = valid[cur_idx] && (tag_array[cur_idx] == cur_tag);
        cnt_done = (cnt == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Write has priority over read when both are requested.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (mem_write) begin
                    next_state = WR_MEM;
                end else if (mem_read && !hit) begin
                    next_state = RD_MISS;
                end
            end
            RD_MISS: if (cnt_done) next_state = IDLE;
            WR_MEM:  if (cnt_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        stall       = 1'b0;
        acc_rd_hit  = 1'b0;
        acc_rd_miss = 1'b0;
        acc_wr      = 1'b0;
        fill_done   = 1'b0;
        wr_done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_write) begin
                    stall  = 1'b1;
                    acc_wr = 1'b1;
                end else if (mem_read) begin
                    if (hit) begin
                        acc_rd_hit = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        acc_rd_miss = 1'b1;
                    end
                end
            end
            RD_MISS: begin
                stall     = 1'b1;
                fill_done = cnt_done;
            end
            WR_MEM: begin
                stall   = 1'b1;
                wr_done = cnt_done;
            end
            default: stall = 1'b1;
        endcase
    end

    // Request latch, latency counter, load result and valid bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            req_addr <= '0;
            req_data <= '0;
            req_hit  <= 1'b0;
            DataOut  <= '0;
            valid    <= '0;
        end else begin
            if (acc_wr || acc_rd_miss) begin
                cnt      <= CNT_W'(MEM_LAT - 1);
                req_addr <= WordAddress;
                req_data <= DataIn;
                req_hit  <= hit;
            end else if ((state != IDLE) && !cnt_done) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (acc_rd_hit) begin
                DataOut <= data_array[cur_idx][cur_off];
            end
            if (fill_done) begin
                DataOut        <= mem_block[req_off];
                valid[req_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays are left untouched by reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_array[req_idx] <= mem_block;
            tag_array[req_idx]  <= req_tag;
        end
        if (wr_done && req_hit) begin
            data_array[req_idx][req_off] <= req_data;
        end
    end

    always_comb begin
        mem_block_addr = block_base(req_tag, req_idx);
    end

    main_memory_model #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BLOCK_WORDS(BLOCK_WORDS)
    ) u_mem (
        .clk       (clk),
        .block_addr(mem_block_addr),
        .block_data(mem_block),
        .wr_en     (wr_done),
        .wr_addr   (req_addr),
        .wr_data   (req_data)
    );

`ifdef CACHE_STATS_EN
    // Read statistics, counted at acceptance and saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (acc_rd_hit && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (acc_rd_miss && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_write_through_cache.sv
// Directed bench for write_through_cache: stall cycle counts and load results
// for hits, misses, write-through, eviction and reset abort.
module tb_write_through_cache;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] WordAddress;
    logic [DW-1:0] DataIn;
    logic          mem_read;
    logic          mem_write;
    logic          stall;
    logic [DW-1:0] DataOut;
`ifdef CACHE_STATS_EN
    logic [15:0]   hit_count;
    logic [15:0]   miss_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    write_through_cache dut (
        .clk        (clk),
        .reset      (reset),
        .WordAddress(WordAddress),
        .DataIn     (DataIn),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .stall      (stall),
        .DataOut    (DataOut)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One request; inputs are scrambled right after acceptance. n = stalled cycles.
    task automatic xact(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        output int n);
        n           = 0;
        WordAddress = addr;
        DataIn      = data;
        mem_write   = wr;
        mem_read    = !wr;
        #1;
        if (stall) n++;
        step();
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        WordAddress = ~addr;
        DataIn      = ~data;
        while (stall && n < 20) begin
            n++;
            step();
        end
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] addr, input int exp_n,
                      input logic [DW-1:0] exp_data);
        int n;
        xact(1'b0, addr, '0, n);
        check({tag, "_stall"}, DW'(n), DW'(exp_n));
        check({tag, "_data"}, DataOut, exp_data);
    endtask

    task automatic wr(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input logic [DW-1:0] exp_hold);
        int n;
        xact(1'b1, addr, data, n);
        check({tag, "_stall"}, DW'(n), DW'(5));
        check({tag, "_hold"}, DataOut, exp_hold);
    endtask

    initial begin
        reset       = 1'b1;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        WordAddress = '0;
        DataIn      = '0;
        step();
        check("rst_stall", DW'(stall), DW'(0));
        check("rst_dout", DataOut, DW'(0));
        reset = 1'b0;
        step();
        check("idle_stall", DW'(stall), DW'(0));

        // Cold read returns power-up contents.
        rd("cold_rd1", 10'd1, 5, DW'(1));

        // Fresh reset, then write miss must not allocate.
        reset = 1'b1;
        #2;
        check("rst2_dout", DataOut, DW'(0));
        reset = 1'b0;
        step();
        wr("wr_miss1", 10'd1, DW'(5), DW'(0));
        rd("rd1_miss", 10'd1, 5, DW'(5));
        rd("rd1_hit", 10'd1, 0, DW'(5));
        rd("rd0_hit", 10'd0, 0, DW'(0));
        rd("rd2_hit", 10'd2, 0, DW'(2));
        rd("rd3_hit", 10'd3, 0, DW'(3));

        // Write hit updates cache and memory.
        wr("wr_hit3", 10'd3, DW'(10), DW'(3));
        rd("rd3_after_wr", 10'd3, 0, DW'(10));

        // Conflict eviction and refill from memory.
        rd("rd129_evict", 10'd129, 5, DW'(129));
        rd("rd1_refill", 10'd1, 5, DW'(5));
        rd("rd3_mem", 10'd3, 0, DW'(10));

        // Reset two cycles into a write aborts it.
        WordAddress = 10'd8;
        DataIn      = DW'(7);
        mem_write   = 1'b1;
        step();
        mem_write = 1'b0;
        step();
        step();
        check("abort_busy", DW'(stall), DW'(1));
        reset = 1'b1;
        #1;
        check("abort_stall", DW'(stall), DW'(0));
        check("abort_dout", DataOut, DW'(0));
        #2;
        reset = 1'b0;
        step();
        rd("rd8_after_abort", 10'd8, 5, DW'(8));
        rd("rd9_hit", 10'd9, 0, DW'(9));
        rd("rd1_persist", 10'd1, 5, DW'(5));
        rd("rd_top", 10'd1023, 5, DW'(1023));
        rd("rd_top_hit", 10'd1020, 0, DW'(1020));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/write_through_cache.md
Name: write_through_cache

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller for a word-addressed CPU port.
- Contains the cache data/tag/valid arrays, the controller FSM and a fixed-latency main-memory model.
- It sits between the CPU datapath and main memory.
- It raises `stall` while a memory transaction is in progress so the CPU holds its request.

Parameters:
- ADDR_WIDTH, 10, word address width; main memory holds 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width.
- BLOCK_WORDS, 4, words per cache line (power of 2); offset bits OFF_W = log2(BLOCK_WORDS).
- NUM_LINES, 32, cache lines (power of 2); index bits IDX_W = log2(NUM_LINES); tag bits TAG_W = ADDR_WIDTH - IDX_W - OFF_W.
- MEM_LAT, 4, main-memory access latency in cycles (block read or single-word write).

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- WordAddress, input, ADDR_WIDTH: word address; split as {tag, index, offset}.
- DataIn, input, DATA_WIDTH: store data.
- mem_read, input, 1: load request.
- mem_write, input, 1: store request.
- stall, output, 1: CPU must hold its request while high.
- DataOut, output, DATA_WIDTH: registered load result.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; all valid bits cleared; DataOut = 0; stall = 0; latency counter = 0.
  - Data/tag arrays and main memory are not cleared.
  - Main memory simulation start-up contents: mem[i] = i.
- States: IDLE, RD_MISS, WR_MEM.
- hit = valid[index] && tag_array[index] == tag.
- Request priority: if mem_write and mem_read are both high, the write wins. Neither high: no request.
- stall is combinational:
  - 1 when state != IDLE;
  - 1 in IDLE when (mem_write) or (mem_read && !hit);
  - otherwise 0.
- Acceptance: on the clock edge in IDLE the request is accepted, and address and data are latched internally. Later changes on the inputs are ignored until return to IDLE.
- Read hit (IDLE):
  - DataOut <= cache word at the next edge; stall stays 0; state stays IDLE; zero stall cycles.
- Read miss (IDLE -> RD_MISS):
  - Counter is loaded with MEM_LAT-1 and decrements each cycle.
  - In the cycle the counter reaches 0, the next edge does all of the following:
    - writes the full aligned block (BLOCK_WORDS words) from memory into the line;
    - sets tag and valid;
    - sets DataOut <= requested word;
    - returns to IDLE.
  - stall is high for exactly 1 + MEM_LAT cycles.
- Write (IDLE -> WR_MEM), hit or miss:
  - Same MEM_LAT counting.
  - At the completing edge, memory[addr] <= data. If the line was a hit at acceptance, the cache word is updated in the same edge.
  - A miss does not allocate (valid/tag unchanged).
  - DataOut is unchanged. stall is high 1 + MEM_LAT cycles.
- Reset mid-operation: the transaction is aborted with no memory or cache update, since all writes occur only at the completing edge. The cache stays coherent.
- DataOut holds its value except on read completion.
- After a miss returns, a still-asserted mem_read in IDLE is a hit: DataOut is re-loaded with the same value and there is no stall.
- Address arithmetic is unsigned. The block base is {tag, index, OFF_W'b0}; no wrap-around is possible inside a block.

Optional Feature:
- CACHE_STATS_EN defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0], reset to 0.
  - A read hit increments hit_count at its acceptance edge. A read miss increments miss_count at its acceptance edge.
  - Writes are not counted. Counters saturate at 16'hFFFF.
- CACHE_STATS_EN undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package cache_pkg:
  - state enum {IDLE, RD_MISS, WR_MEM};
  - derived width localparams OFF_W, IDX_W, TAG_W;
  - address field-extraction functions.
- One sub-module: main_memory_model. It holds the 2**ADDR_WIDTH x DATA_WIDTH array, a block-read port (BLOCK_WORDS words) and a word-write port.
- Controller FSM and cache arrays stay in write_through_cache.

Test Plan:
- Reset then idle: stall = 0, DataOut = 0; a read of addr 1 misses, stall high 5 cycles, then DataOut = 1 (power-up contents).
- Write 5 to addr 1 after reset (miss): stall high 5 cycles, line not allocated. Then read addr 1: miss, 5 stall cycles, DataOut = 5.
- Read addr 1 again: hit, stall stays 0, DataOut = 5 at the next edge. Reads of addr 0, 2, 3 also hit, returning 0, 2, 3.
- Write 10 to addr 3 (hit): stall high 5 cycles. Then read addr 3: hit, no stall, DataOut = 10. Memory word 3 = 10.
- Conflict: read addr 129 (same index, different tag) misses and evicts. A read of addr 1 then misses again and returns 5.
- Assert reset two cycles into a write of 7 to addr 8: stall drops immediately. A later read of addr 8 returns 8.
